// File: rtl/pwm_pkg.sv
// Shared types, constants and helpers for the PWM output stage.
// The optional duty shadow register is enabled with the PWM_DUTY_SHADOW_EN macro.
package pwm_pkg;

    localparam int            PWM_CNT_W = 8;
    localparam logic [7:0]    DUTY_FULL = 8'hFF;
    localparam int            NUM_OUT   = 16;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
    typedef logic [NUM_OUT-1:0]   out_vec_t;

    // Full-scale duty forces constant high so 0xFF really means 100 %.
    function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
        logic raw;
        if (duty == DUTY_FULL) begin
            raw = 1'b1;
        end else begin
            raw = (cnt < duty);
        end
        return raw;
    endfunction

    function automatic out_vec_t out_mux(input out_vec_t en_out,
                                         input out_vec_t en_pwm,
                                         input logic     raw);
        return en_out & (~en_pwm | {NUM_OUT{raw}});
    endfunction

endpackage

// File: rtl/pwm_output_stage_if.sv
// Register-bank to output-stage bundle: configuration registers in, chip outputs back.
interface pwm_output_stage_if;
    import pwm_pkg::*;

    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    out_vec_t   out;
    logic       period_start;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle,
        input  out, period_start
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle,
        output out, period_start
    );

endinterface

// File: rtl/pwm_timebase.sv
// PWM timebase: clock prescaler feeding a free-running 8-bit period counter,
// plus the registered period_start pulse one clk after each 255->0 wrap.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = 13
) (
    input  logic     clk,
    input  logic     rst_n,
    output pwm_cnt_t o_pwm_cnt,
    output logic     o_tick,
    output logic     o_wrap,
    output logic     o_period_start
);

    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    typedef logic [PW-1:0] presc_t;

    localparam presc_t   PRESC_MAX  = presc_t'(PRESCALE_DIV - 1);
    localparam presc_t   PRESC_ZERO = presc_t'(0);
    localparam presc_t   PRESC_ONE  = presc_t'(1);
    localparam pwm_cnt_t CNT_ZERO   = pwm_cnt_t'(0);
    localparam pwm_cnt_t CNT_ONE    = pwm_cnt_t'(1);
    localparam pwm_cnt_t CNT_LAST   = pwm_cnt_t'(255);

    presc_t   r_presc;
    presc_t   w_presc_nxt;
    pwm_cnt_t r_cnt;
    pwm_cnt_t w_cnt_nxt;
    logic     r_period_start;
    logic     w_tick;
    logic     w_wrap;

    // Next-state for prescaler and period counter; the counter wraps by overflow.
    always_comb begin
        w_tick      = (r_presc == PRESC_MAX);
        w_wrap      = w_tick && (r_cnt == CNT_LAST);
        w_presc_nxt = r_presc;
        w_cnt_nxt   = r_cnt;
        if (w_tick) begin
            w_presc_nxt = PRESC_ZERO;
            w_cnt_nxt   = r_cnt + CNT_ONE;
        end else begin
            w_presc_nxt = r_presc + PRESC_ONE;
            w_cnt_nxt   = r_cnt;
        end
    end

    // Timebase state and the registered period boundary pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc        <= PRESC_ZERO;
            r_cnt          <= CNT_ZERO;
            r_period_start <= 1'b0;
        end else begin
            r_presc        <= w_presc_nxt;
            r_cnt          <= w_cnt_nxt;
            r_period_start <= w_wrap;
        end
    end

    assign o_pwm_cnt      = r_cnt;
    assign o_tick         = w_tick;
    assign o_wrap         = w_wrap;
    assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage: drives 16 outputs low, static high or from one shared PWM waveform.
// Define PWM_DUTY_SHADOW_EN to latch the duty code only at period boundaries.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_output_stage_if.slave  bus
);

    pwm_cnt_t w_pwm_cnt;
    pwm_cnt_t w_duty_active;
    logic     w_tick;
    logic     w_wrap;
    logic     w_period_start;
    logic     w_pwm_raw;
    out_vec_t w_en_out;
    out_vec_t w_en_pwm;
    out_vec_t r_out;

    pwm_timebase #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_timebase (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_pwm_cnt      (w_pwm_cnt),
        .o_tick         (w_tick),
        .o_wrap         (w_wrap),
        .o_period_start (w_period_start)
    );

`ifdef PWM_DUTY_SHADOW_EN
    pwm_cnt_t r_duty_active;
    logic     w_unused_wrap;

    assign w_unused_wrap = w_wrap;

    // Shadow duty: a new code only takes effect at the next period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_active <= 8'h00;
        end else if (w_tick && (w_pwm_cnt == DUTY_FULL)) begin
            r_duty_active <= bus.pwm_duty_cycle;
        end else begin
            r_duty_active <= r_duty_active;
        end
    end

    assign w_duty_active = r_duty_active;
`else
    logic w_unused_timebase;

    assign w_unused_timebase = w_tick | w_wrap;
    assign w_duty_active     = bus.pwm_duty_cycle;
`endif

    assign w_en_out  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign w_en_pwm  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    assign w_pwm_raw = pwm_compare(w_pwm_cnt, w_duty_active);

    // Output register: every bit samples the same raw waveform, so PWM bits switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 16'h0000;
        end else begin
            r_out <= out_mux(w_en_out, w_en_pwm, w_pwm_raw);
        end
    end

    assign bus.out          = r_out;
    assign bus.period_start = w_period_start;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage: cycle model from elapsed-time arithmetic,
// table-driven per-period high-time vectors, randomized register traffic and corner sequences.
module tb_pwm_output_stage;
    import pwm_pkg::*;

    localparam int DIV    = 13;
    localparam int PERIOD = DIV * 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pwm_output_stage_if bus ();

    pwm_output_stage #(
        .PRESCALE_DIV (DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_n     = 0;
    logic [7:0]  m_duty  = 8'h00;
    logic [15:0] m_out   = 16'h0000;
    logic        m_ps    = 1'b0;
    int          hi_cnt [16];

    typedef struct {
        logic [15:0] eo;
        logic [15:0] ep;
        logic [7:0]  duty;
        int          pwm_hi;
        int          nper;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        bus.en_reg_out_7_0  = eo[7:0];
        bus.en_reg_out_15_8 = eo[15:8];
        bus.en_reg_pwm_7_0  = ep[7:0];
        bus.en_reg_pwm_15_8 = ep[15:8];
        bus.pwm_duty_cycle  = d;
    endtask

    // One clock: advance the reference model from elapsed cycles, then compare.
    task automatic step();
        int          cnt;
        logic [7:0]  da;
        logic        raw;
        logic [15:0] eo;
        logic [15:0] ep;
        @(posedge clk);
        if (!rst_n) begin
            m_n    = 0;
            m_out  = 16'h0000;
            m_ps   = 1'b0;
            m_duty = 8'h00;
        end else begin
            m_n++;
            cnt = ((m_n - 1) / DIV) % 256;
`ifdef PWM_DUTY_SHADOW_EN
            da = m_duty;
`else
            da = bus.pwm_duty_cycle;
`endif
            raw = (da == 8'hFF) ? 1'b1 : (cnt < int'(da));
            eo  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
            ep  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
            for (int i = 0; i < 16; i++) begin
                if (!eo[i])      m_out[i] = 1'b0;
                else if (!ep[i]) m_out[i] = 1'b1;
                else             m_out[i] = raw;
            end
            m_ps = ((m_n % PERIOD) == 0);
            if (m_ps) m_duty = bus.pwm_duty_cycle;
        end
        #1;
        check("model_out", {16'h0000, bus.out}, {16'h0000, m_out});
        check("model_period_start", {31'd0, bus.period_start}, {31'd0, m_ps});
    endtask

    task automatic wait_ps(input int bound, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!bus.period_start && cycles < bound);
        if (!bus.period_start) check("period_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic measure(input int nper);
        for (int i = 0; i < 16; i++) hi_cnt[i] = 0;
        for (int k = 0; k < nper * PERIOD; k++) begin
            step();
            for (int i = 0; i < 16; i++) if (bus.out[i]) hi_cnt[i]++;
        end
    endtask

    initial begin
        int c;
        int hi;
        int exp_hi;

        tbl[0] = '{16'hFFFF, 16'hFFFF, 8'h80, 1664, 1};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 8'hFF, 3328, 3};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 8'h01, 13,   1};
        tbl[3] = '{16'hF0F0, 16'hFF00, 8'h40, 832,  1};
        tbl[4] = '{16'h00FF, 16'h0FFF, 8'hC0, 2496, 1};

        // Reset hold and first period boundary.
        set_regs(16'h0000, 16'h0000, 8'h00);
        repeat (5) step();
        check("reset_out", {16'h0000, bus.out}, 32'h0);
        check("reset_period_start", {31'd0, bus.period_start}, 32'd0);
        rst_n = 1'b1;
        wait_ps(PERIOD + 100, c);
        check("first_period_start_latency", c, PERIOD);

        // Static enable and disabled PWM bit.
        set_regs(16'h0001, 16'h0000, 8'h00);
        step();
        check("static_bit0", {16'h0000, bus.out}, 32'h0001);
        set_regs(16'h8000, 16'h8000, 8'h00);
        step();
        check("pwm_duty0_bit15", {16'h0000, bus.out}, 32'h0000);
        repeat (20) step();

        // Table: per-bit high time over whole aligned periods.
        for (int v = 0; v < 5; v++) begin
            set_regs(tbl[v].eo, tbl[v].ep, tbl[v].duty);
            wait_ps(PERIOD + 100, c);
            measure(tbl[v].nper);
            for (int i = 0; i < 16; i++) begin
                if (!tbl[v].eo[i])      exp_hi = 0;
                else if (!tbl[v].ep[i]) exp_hi = PERIOD * tbl[v].nper;
                else                    exp_hi = tbl[v].pwm_hi * tbl[v].nper;
                check($sformatf("vec%0d_bit%0d_high", v, i), hi_cnt[i], exp_hi);
            end
        end

        // Rising edge comes one clk after period_start with duty 0x80.
        set_regs(16'hFFFF, 16'hFFFF, 8'h80);
        wait_ps(PERIOD + 100, c);
        wait_ps(PERIOD + 100, c);
        check("edge_before_boundary", {16'h0000, bus.out}, 32'h0000);
        step();
        check("rise_after_period_start", {16'h0000, bus.out}, 32'hFFFF);

        // Mid-period duty change 0x40 -> 0xC0 at pwm_cnt 0x20.
        set_regs(16'hFFFF, 16'hFFFF, 8'h40);
        wait_ps(PERIOD + 100, c);
        wait_ps(PERIOD + 100, c);
        hi = 0;
        for (int k = 1; k <= PERIOD; k++) begin
            step();
            if (bus.out[0]) hi++;
            if (k == 32 * DIV) bus.pwm_duty_cycle = 8'hC0;
        end
`ifdef PWM_DUTY_SHADOW_EN
        check("duty_change_current_period", hi, 832);
`else
        check("duty_change_current_period", hi, 2496);
`endif
        measure(1);
        check("duty_change_next_period", hi_cnt[0], 2496);

        // Randomized register traffic against the model.
        for (int r = 0; r < 30; r++) begin
            case ($urandom_range(0, 3))
                0:       c = 0;
                1:       c = 255;
                default: c = $urandom_range(0, 255);
            endcase
            set_regs(16'($urandom), 16'($urandom), 8'(c));
            repeat ($urandom_range(50, 400)) step();
        end

        // Async reset at pwm_cnt 0x50 with all outputs high.
        set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
        wait_ps(PERIOD + 100, c);
        wait_ps(PERIOD + 100, c);
        repeat (8'h50 * DIV) step();
        check("pre_reset_all_high", {16'h0000, bus.out}, 32'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", {16'h0000, bus.out}, 32'h0000);
        repeat (3) step();
        rst_n = 1'b1;
        wait_ps(PERIOD + 100, c);
        check("period_start_after_reset", c, PERIOD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
Downstream consumer of the SPI register bank. Takes the five configuration registers (output enables, PWM-mode enables, duty cycle) and drives the 16 chip outputs. Each output is forced low, held static high, or driven by a shared 8-bit PWM waveform. The waveform timebase is a clock prescaler feeding a free-running 8-bit period counter.

Parameters:
PRESCALE_DIV, 13, clk cycles per PWM count step (≥2); PWM period = PRESCALE_DIV*256 clk cycles
NUM_OUT, 16, number of driven outputs (fixed at 16 for the register map)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
en_reg_out_7_0  input  8  output enable, out[7:0]
en_reg_out_15_8  input  8  output enable, out[15:8]
en_reg_pwm_7_0  input  8  PWM-mode select, out[7:0]
en_reg_pwm_15_8  input  8  PWM-mode select, out[15:8]
pwm_duty_cycle  input  8  duty code; 0x00 = 0%, 0xFF = 100%
out  output  16  chip outputs
period_start  output  1  one-clk pulse at each PWM period boundary

Behaviour:
- Reset is asynchronous and active-low: out=0, period_start=0, prescaler=0, pwm_cnt=0, duty_active=0.
- Register inputs are clk-domain and quasi-static. They are sampled every clk and are not synchronized.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1, then wraps to 0.
  - tick=1 combinationally when prescaler==PRESCALE_DIV-1.
- pwm_cnt:
  - 8-bit; increments on tick; wraps from 255 to 0 (no saturation).
- period_start:
  - Registered; =1 for exactly the one clk after the tick that wraps pwm_cnt from 255 to 0.
  - First pulse: 256*PRESCALE_DIV clk after reset release.
- duty_active loading: see Optional Feature.
- pwm_raw (combinational):
  - duty_active==0xFF → 1.
  - Otherwise → (pwm_cnt < duty_active).
  - Result: duty 0x00 gives constant 0; duty N (1..254) gives high for N*PRESCALE_DIV clk per period.
- Output mux, per bit i, registered into out[i]:
  - en_out[i]=0 → 0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0 → 1.
  - en_out[i]=1, en_pwm[i]=1 → pwm_raw.
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm is built the same way.
- Latency: any enable or pwm_cnt change appears on out after 1 clk.
- All PWM-mode outputs share one waveform and switch in the same clk (no phase offset).
- Reset asserted mid-period: out drops to 0 immediately (async). After release, the timebase restarts from 0 with no partial-period carry-over.

Optional Feature:
Macro PWM_DUTY_SHADOW_EN.
- Defined:
  - duty_active is a shadow register.
  - Loaded from pwm_duty_cycle only on the clk where tick=1 and pwm_cnt==255 (the period boundary).
  - Mid-period duty writes take effect from the next period. No runt pulses or truncated highs.
- Undefined:
  - duty_active is pwm_duty_cycle directly; the compare uses the live value.
  - A mid-period change affects the current period; a single glitched period is permitted.
- period_start behaviour is identical in both builds.

Decomposition:
- Package pwm_pkg:
  - PWM_CNT_W=8
  - DUTY_FULL=8'hFF
  - NUM_OUT=16
  - typedef pwm_cnt_t (logic [7:0])
  - typedef out_vec_t (logic [15:0])
- Sub-module pwm_timebase: prescaler + pwm_cnt + period_start generation, exporting pwm_cnt, tick and the wrap strobe.
- pwm_output_stage instantiates pwm_timebase and holds the duty logic and the output mux.

Test Plan (PRESCALE_DIV=13, period 3328 clk):
1. Reset hold, then release with all registers 0 → out=0x0000 and period_start=0 throughout. First period_start pulse exactly 3328 clk after release.
2. en_out=0x0001, en_pwm=0x0000 → out=0x0001 one clk after the write. Then en_out=0x8000, en_pwm=0x8000 with duty 0x00 → out=0x0000 constantly.
3. en_out=0xFFFF, en_pwm=0xFFFF, duty=0x80 → every bit high 1664 clk and low 1664 clk per period. Rising edge 1 clk after period_start; all 16 bits toggle in the same clk.
4. Same enables with duty=0xFF → out=0xFFFF constantly, no low cycle across 3 periods. Then duty=0x01 → high exactly 13 clk per period.
5. PWM_DUTY_SHADOW_EN defined, duty=0x40, switched to 0xC0 at pwm_cnt=0x20 → current period high 832 clk; next period high 2496 clk. Undefined build: current period high until pwm_cnt reaches 0xC0.
6. Assert rst_n at pwm_cnt=0x50 while out=0xFFFF → out=0x0000 in the same cycle (async). After release, period_start again arrives 3328 clk later.
